permutation_ctrl: RTL and testbench

// - Sequences the Ascon permutation: runs p12 or p6 rounds on a 320-bit state held in an internal register.
// - Each round applies constant addition, then the substitution layer, then the linear diffusion layer.
// - Sits between the Ascon-128 top-level FSM (init/AD/plaintext/finalisation) and the round datapath.
// - Owns the round counter and the round-constant generation.

---
 rtl/permutation_ctrl_pkg.sv | 54 +++++
 rtl/permutation_ctrl_round.sv | 13 +
 rtl/permutation_ctrl.sv | 109 ++++++++++
 tb/tb_permutation_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/permutation_ctrl_pkg.sv
// Shared Ascon types, constants and the three round-layer functions.
package ascon_pack;

    // x0 sits at index 0, so {x0, x1, x2, x3, x4} builds a state in natural order.
    typedef logic [0:4][63:0] type_state;

    typedef enum logic [1:0] {IDLE, RUN, DONE} type_perm_fsm;

    localparam int unsigned ROUNDS_P12 = 12;
    localparam int unsigned ROUNDS_P6  = 6;
    localparam int unsigned P6_START   = 6;
    localparam int unsigned CNT_W      = 4;

    // Round constant for round index i: high nibble counts down from F, low nibble up from 0.
    function automatic logic [7:0] round_const(input logic [3:0] i);
        return {4'hF - i, i};
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned r);
        return (x >> r) | (x << (64 - r));
    endfunction

    // Round constant lands in the low byte of x2.
    function automatic type_state constant_addition(input type_state s, input logic [7:0] rc);
        type_state r;
        r = s;
        r[2][7:0] = s[2][7:0] ^ rc;
        return r;
    endfunction

    // Bit-sliced 5-bit S-box applied to all 64 columns at once.
    function automatic type_state substitution_layer(input type_state s);
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
        x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
        t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
        x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
        x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
        return {x0, x1, x2, x3, x4};
    endfunction

    // Per-word linear diffusion: each word XORed with two rotations of itself.
    function automatic type_state diffusion_layer(input type_state s);
        type_state r;
        r[0] = s[0] ^ rotr(s[0], 19) ^ rotr(s[0], 28);
        r[1] = s[1] ^ rotr(s[1], 61) ^ rotr(s[1], 39);
        r[2] = s[2] ^ rotr(s[2], 1)  ^ rotr(s[2], 6);
        r[3] = s[3] ^ rotr(s[3], 10) ^ rotr(s[3], 17);
        r[4] = s[4] ^ rotr(s[4], 7)  ^ rotr(s[4], 41);
        return r;
    endfunction

endpackage

// File: rtl/permutation_ctrl_round.sv
// One combinational Ascon round: constant addition, S-box layer, linear layer.
module ascon_round
    import ascon_pack::*;
(
    input  type_state  round_i,
    input  logic [7:0] rc_i,
    output type_state  round_o
);

    // Chain the three layers in round order.
    assign round_o = diffusion_layer(substitution_layer(constant_addition(round_i, rc_i)));

endmodule

// File: rtl/permutation_ctrl.sv
// Ascon permutation sequencer: runs p12 or p6 over an internal 320-bit state,
// UNROLL rounds per clock, with its own round counter and constants.
module permutation_ctrl
    import ascon_pack::*;
#(
    parameter int unsigned UNROLL = 1
) (
    input  logic      clock_i,
    input  logic      resetb_i,
    input  logic      start_i,
    input  logic      mode_i,
    input  type_state state_i,
    output type_state state_o,
    output logic      busy_o,
    output logic      done_o
);

    localparam logic [CNT_W:0] LAST_SUM = (CNT_W + 1)'(ROUNDS_P12);

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 3 || UNROLL == 6)) begin : g_bad_unroll
        $error("permutation_ctrl: UNROLL must be 1, 2, 3 or 6");
    end

    type_perm_fsm     fsm_q, fsm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    type_state        state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W:0]   cnt_sum;
    type_state        chain [UNROLL+1];

    assign chain[0] = state_q;
    assign cnt_sum  = (CNT_W + 1)'(cnt_q) + (CNT_W + 1)'(UNROLL);

    // UNROLL rounds in series, round g using the constant for index cnt+g.
    for (genvar g = 0; g < UNROLL; g++) begin : g_round
        localparam logic [CNT_W-1:0] OFFS = CNT_W'(g);
        ascon_round u_round (
            .round_i (chain[g]),
            .rc_i    (round_const(cnt_q + OFFS)),
            .round_o (chain[g+1])
        );
    end

    // Next-state, counter and state-register update; status flags are precomputed for registering.
    always_comb begin
        fsm_d   = fsm_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (start_i) begin
                    state_d = state_i;
                    cnt_d   = mode_i ? CNT_W'(P6_START) : '0;
                    fsm_d   = RUN;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                state_d = chain[UNROLL];
                cnt_d   = cnt_sum[CNT_W-1:0];
                if (cnt_sum == LAST_SUM) begin
                    fsm_d  = DONE;
                    done_d = 1'b1;
                end else begin
                    busy_d = 1'b1;
                end
            end
            DONE: begin
                fsm_d = IDLE;
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    // State register; reset aborts any permutation in flight.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            fsm_q   <= IDLE;
            cnt_q   <= '0;
            state_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Round counter must stay within the 12-round schedule.
    always_ff @(posedge clock_i) begin
        if (resetb_i) begin
            assert (cnt_q <= CNT_W'(ROUNDS_P12))
                else $error("permutation_ctrl: round counter out of range");
        end
    end

    assign state_o = state_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule

// File: tb/tb_permutation_ctrl.sv
// Bench for permutation_ctrl: UNROLL=1 and UNROLL=3 instances against a
// table-driven Ascon permutation model.
module tb_permutation_ctrl;
    import ascon_pack::*;

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
    localparam int ROT1 [5] = '{19, 61, 1, 10, 7};
    localparam int ROT2 [5] = '{28, 39, 6, 17, 41};

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start0 = 1'b0, start1 = 1'b0;
    logic mode0 = 1'b0, mode1 = 1'b0;
    type_state sin0 = '0, sin1 = '0;
    type_state sout0, sout1;
    logic busy0, busy1, done0, done1;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    permutation_ctrl #(.UNROLL(1)) dut1 (
        .clock_i(clk), .resetb_i(rst_n), .start_i(start0), .mode_i(mode0),
        .state_i(sin0), .state_o(sout0), .busy_o(busy0), .done_o(done0));

    permutation_ctrl #(.UNROLL(3)) dut3 (
        .clock_i(clk), .resetb_i(rst_n), .start_i(start1), .mode_i(mode1),
        .state_i(sin1), .state_o(sout1), .busy_o(busy1), .done_o(done1));

    // Reference: n rounds starting at round index 'first', S-box by table lookup per column.
    function automatic type_state model_rounds(input type_state s, input int first, input int n);
        logic [63:0] x [5];
        logic [63:0] y [5];
        logic [4:0]  col, o;
        for (int k = 0; k < 5; k++) x[k] = s[k];
        for (int r = first; r < first + n; r++) begin
            x[2] = x[2] ^ 64'((15 - r) * 16 + r);
            for (int b = 0; b < 64; b++) begin
                col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
                o = SBOX[col];
                for (int k = 0; k < 5; k++) y[k][b] = o[4-k];
            end
            for (int k = 0; k < 5; k++)
                for (int b = 0; b < 64; b++)
                    x[k][b] = y[k][b] ^ y[k][(b + ROT1[k]) % 64] ^ y[k][(b + ROT2[k]) % 64];
        end
        for (int k = 0; k < 5; k++) s[k] = x[k];
        return s;
    endfunction

    function automatic type_state model_perm(input type_state s, input logic m);
        return m ? model_rounds(s, 6, 6) : model_rounds(s, 0, 12);
    endfunction

    function automatic int exp_lat(input int d, input logic m);
        return (m ? 6 : 12) / (d == 0 ? 1 : 3) + 1;
    endfunction

    function automatic type_state rand_state();
        type_state r;
        for (int k = 0; k < 5; k++) r[k] = {$urandom, $urandom};
        return r;
    endfunction

    function automatic type_state get_state(input int d);
        return (d == 0) ? sout0 : sout1;
    endfunction
    function automatic logic get_busy(input int d);
        return (d == 0) ? busy0 : busy1;
    endfunction
    function automatic logic get_done(input int d);
        return (d == 0) ? done0 : done1;
    endfunction

    task automatic drive(input int d, input logic st, input logic m, input type_state s);
        if (d == 0) begin start0 = st; mode0 = m; sin0 = s; end
        else        begin start1 = st; mode1 = m; sin1 = s; end
    endtask

    // Stimulus driver: one permutation on instance d, collecting what happened (no checking here).
    task automatic do_run(input int d, input type_state s, input logic m, input bit inject,
                          input bit start_in_done, input int tail,
                          output int lat, output int ndone, output type_state first,
                          output type_state res, output bit stable, output bit busy_ok,
                          output bit tail_busy);
        int n;
        bit seen;
        lat = 0; ndone = 0; seen = 0; stable = 1; busy_ok = 1; tail_busy = 0;
        res = '0; first = '0;
        drive(d, 1'b1, m, s);
        n = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            drive(d, 1'b0, 1'($urandom), rand_state());
            if (inject && (n == 3 || n == 8)) drive(d, 1'b1, ~m, rand_state());
            if (n == 2) first = get_state(d);
            if (get_done(d) === 1'b1) begin
                seen = 1; lat = n; res = get_state(d); ndone++;
                if (start_in_done) drive(d, 1'b1, m, rand_state());
            end else if (get_busy(d) !== 1'b1) begin
                busy_ok = 0;
            end
        end
        for (int k = 0; k < tail; k++) begin
            @(negedge clk);
            drive(d, 1'b0, 1'b0, rand_state());
            if (get_done(d) === 1'b1) ndone++;
            if (get_busy(d) !== 1'b0) tail_busy = 1;
            if (get_state(d) !== res) stable = 0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            total_cnt++;
            if (get_busy(d) !== 1'b0 || get_done(d) !== 1'b0 || get_state(d) !== '0)
                $display("FAIL reset_hold[%0d]: busy=%b done=%b state=%h required 0/0/0", d,
                         get_busy(d), get_done(d), get_state(d));
            else pass_cnt++;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                total_cnt++;
                if (get_busy(d) !== 1'b0 || get_done(d) !== 1'b0 || get_state(d) !== '0)
                    $display("FAIL reset_idle[%0d] cyc %0d: busy=%b done=%b state=%h required 0/0/0",
                             d, c, get_busy(d), get_done(d), get_state(d));
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_p12();
        type_state s, first, res;
        int lat, nd;
        bit stable, bok, tb;
        s = {64'h80400c0600000000, 64'h0, 64'h0, 64'h0, 64'h0};
        do_run(0, s, 1'b0, 0, 0, 6, lat, nd, first, res, stable, bok, tb);
        total_cnt++;
        if (lat !== 13) $display("FAIL p12_latency: got %0d required 13", lat); else pass_cnt++;
        total_cnt++;
        if (res !== model_perm(s, 1'b0)) $display("FAIL p12_result: got %h required %h", res, model_perm(s, 1'b0));
        else pass_cnt++;
        total_cnt++;
        if (first !== model_rounds(s, 0, 1)) $display("FAIL p12_first_round: got %h required %h", first, model_rounds(s, 0, 1));
        else pass_cnt++;
        total_cnt++;
        if (nd !== 1 || !stable || !bok || tb)
            $display("FAIL p12_handshake: done_pulses=%0d stable=%0d busy_ok=%0d tail_busy=%0d required 1/1/1/0", nd, stable, bok, tb);
        else pass_cnt++;
    endtask

    task automatic test_p6();
        type_state s, first, res;
        int lat, nd;
        bit stable, bok, tb;
        s = {64'h78e2cc41faabaa1a, 64'hbc7a2e775aababf7, 64'h4b81c0cbbdb5fc1a,
             64'hb22e133e424f0250, 64'h044d33702433805d};
        do_run(0, s, 1'b1, 0, 0, 3, lat, nd, first, res, stable, bok, tb);
        total_cnt++;
        if (lat !== 7) $display("FAIL p6_latency: got %0d required 7", lat); else pass_cnt++;
        total_cnt++;
        if (res !== model_perm(s, 1'b1)) $display("FAIL p6_result: got %h required %h", res, model_perm(s, 1'b1));
        else pass_cnt++;
        total_cnt++;
        if (first !== model_rounds(s, 6, 1)) $display("FAIL p6_first_round_rc96: got %h required %h", first, model_rounds(s, 6, 1));
        else pass_cnt++;
        total_cnt++;
        if (nd !== 1 || !stable || !bok) $display("FAIL p6_handshake: done_pulses=%0d stable=%0d busy_ok=%0d required 1/1/1", nd, stable, bok);
        else pass_cnt++;
    endtask

    task automatic test_start_while_busy();
        type_state s, first, res;
        int lat, nd;
        bit stable, bok, tb;
        s = {64'h80400c0600000000, 64'h0, 64'h0, 64'h0, 64'h0};
        do_run(0, s, 1'b0, 1, 0, 8, lat, nd, first, res, stable, bok, tb);
        total_cnt++;
        if (res !== model_perm(s, 1'b0)) $display("FAIL busy_start_result: got %h required %h", res, model_perm(s, 1'b0));
        else pass_cnt++;
        total_cnt++;
        if (nd !== 1 || lat !== 13 || tb) $display("FAIL busy_start_pulses: done_pulses=%0d latency=%0d tail_busy=%0d required 1/13/0", nd, lat, tb);
        else pass_cnt++;
    endtask

    task automatic test_start_in_done();
        type_state s, first, res;
        int lat, nd;
        bit stable, bok, tb;
        s = rand_state();
        do_run(0, s, 1'b1, 0, 1, 6, lat, nd, first, res, stable, bok, tb);
        total_cnt++;
        if (tb || nd !== 1 || !stable)
            $display("FAIL done_start_ignored: tail_busy=%0d done_pulses=%0d stable=%0d required 0/1/1", tb, nd, stable);
        else pass_cnt++;
        total_cnt++;
        if (res !== model_perm(s, 1'b1)) $display("FAIL done_start_result: got %h required %h", res, model_perm(s, 1'b1));
        else pass_cnt++;
    endtask

    task automatic test_reset_midrun();
        type_state s, first, res;
        int lat, nd;
        bit stable, bok, tb, spurious;
        drive(0, 1'b1, 1'b0, rand_state());
        @(negedge clk);
        drive(0, 1'b0, 1'b0, '0);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (sout0 !== '0 || busy0 !== 1'b0 || done0 !== 1'b0)
            $display("FAIL midrun_reset: busy=%b done=%b state=%h required 0/0/0", busy0, done0, sout0);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        spurious = 0;
        repeat (15) begin
            @(negedge clk);
            if (done0 !== 1'b0 || busy0 !== 1'b0) spurious = 1;
        end
        total_cnt++;
        if (spurious) $display("FAIL midrun_no_done: saw busy/done after abort, required none");
        else pass_cnt++;
        s = rand_state();
        do_run(0, s, 1'b1, 0, 0, 2, lat, nd, first, res, stable, bok, tb);
        total_cnt++;
        if (res !== model_perm(s, 1'b1) || lat !== 7)
            $display("FAIL midrun_recover: got %h lat %0d required %h lat 7", res, lat, model_perm(s, 1'b1));
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        type_state a, b, first, ra, rb;
        int la, lb, nd;
        bit stable, bok, tb;
        a = rand_state();
        b = rand_state();
        do_run(0, a, 1'b0, 0, 0, 1, la, nd, first, ra, stable, bok, tb);
        do_run(0, b, 1'b1, 0, 0, 3, lb, nd, first, rb, stable, bok, tb);
        total_cnt++;
        if (ra !== model_perm(a, 1'b0) || la !== 13)
            $display("FAIL b2b_first: got %h lat %0d required %h lat 13", ra, la, model_perm(a, 1'b0));
        else pass_cnt++;
        total_cnt++;
        if (rb !== model_perm(b, 1'b1) || lb !== 7)
            $display("FAIL b2b_second: got %h lat %0d required %h lat 7", rb, lb, model_perm(b, 1'b1));
        else pass_cnt++;
    endtask

    task automatic test_unroll3();
        type_state s, first, res;
        int lat, nd;
        bit stable, bok, tb;
        s = {64'h80400c0600000000, 64'h0, 64'h0, 64'h0, 64'h0};
        do_run(1, s, 1'b0, 0, 0, 3, lat, nd, first, res, stable, bok, tb);
        total_cnt++;
        if (lat !== 5 || res !== model_perm(s, 1'b0) || nd !== 1)
            $display("FAIL u3_p12: got %h lat %0d pulses %0d required %h lat 5 pulses 1", res, lat, nd, model_perm(s, 1'b0));
        else pass_cnt++;
        total_cnt++;
        if (first !== model_rounds(s, 0, 3)) $display("FAIL u3_p12_first: got %h required %h", first, model_rounds(s, 0, 3));
        else pass_cnt++;
        s = {64'h78e2cc41faabaa1a, 64'hbc7a2e775aababf7, 64'h4b81c0cbbdb5fc1a,
             64'hb22e133e424f0250, 64'h044d33702433805d};
        do_run(1, s, 1'b1, 0, 0, 3, lat, nd, first, res, stable, bok, tb);
        total_cnt++;
        if (lat !== 3 || res !== model_perm(s, 1'b1) || nd !== 1)
            $display("FAIL u3_p6: got %h lat %0d pulses %0d required %h lat 3 pulses 1", res, lat, nd, model_perm(s, 1'b1));
        else pass_cnt++;
        total_cnt++;
        if (first !== model_rounds(s, 6, 3)) $display("FAIL u3_p6_first: got %h required %h", first, model_rounds(s, 6, 3));
        else pass_cnt++;
    endtask

    task automatic test_random();
        type_state s, first, res;
        int lat, nd;
        bit stable, bok, tb;
        logic m;
        for (int i = 0; i < 8; i++) begin
            s = rand_state();
            m = 1'($urandom);
            do_run(i % 2, s, m, 0, 0, 1 + (i % 3), lat, nd, first, res, stable, bok, tb);
            total_cnt++;
            if (res !== model_perm(s, m) || lat !== exp_lat(i % 2, m) || !bok || !stable)
                $display("FAIL random[%0d] inst %0d mode %0d: got %h lat %0d busy_ok %0d stable %0d required %h lat %0d",
                         i, i % 2, m, res, lat, bok, stable, model_perm(s, m), exp_lat(i % 2, m));
            else pass_cnt++;
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_p12();
        test_p6();
        test_start_while_busy();
        test_start_in_done();
        test_reset_midrun();
        test_back_to_back();
        test_unroll3();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
